sao_eo_stat_accum: RTL

//  Parametrised SAO edge-offset statistics collector. Each cycle it takes N_PIX pixel lanes.
//  Per lane it classifies the pixel into EO category 1..4 and clips (org-rec).
//  Per category it accumulates the sum of clipped diffs and a pixel count over one block (CTB).

---
 rtl/sao_eo_stat_accum_pkg.sv | 39 +++
 rtl/sao_eo_stat_accum_if.sv | 34 +++
 rtl/sao_eo_stat_accum_classify.sv | 43 ++++
 rtl/sao_eo_stat_accum.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/sao_eo_stat_accum_pkg.sv
// Shared types and helpers for the SAO edge-offset statistics collector.
package sao_eo_stat_accum_pkg;

   localparam int BIT_DEPTH_DEF     = 8;
   localparam int DIFF_CLIP_BIT_DEF = 4;

   typedef logic [BIT_DEPTH_DEF-1:0]            sample_t;
   typedef logic signed [DIFF_CLIP_BIT_DEF:0]   diff_t;
   typedef logic signed [1:0]                   sgn_t;

   typedef enum logic [2:0] {
      CAT_NONE = 3'd0,
      CAT1     = 3'd1,
      CAT2     = 3'd2,
      CAT3     = 3'd3,
      CAT4     = 3'd4
   } sao_cat_e;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2,
      ST_OUT   = 2'd3
   } sao_state_e;

   // Edge class from the two neighbour signs: valley -> CAT1 ... peak -> CAT4.
   function automatic sao_cat_e sao_eo_cat(input sgn_t s_a, input sgn_t s_b);
      logic signed [2:0] e;
      e = {s_a[1], s_a} + {s_b[1], s_b};
      case (e)
         3'b110:  return CAT1;
         3'b111:  return CAT2;
         3'b001:  return CAT3;
         3'b010:  return CAT4;
         default: return CAT_NONE;
      endcase
   endfunction

endpackage

// File: rtl/sao_eo_stat_accum_if.sv
// Beat input and statistics output bundle of the SAO EO statistics collector.
interface sao_eo_stat_accum_if #(
   parameter int BIT_DEPTH = 8,
   parameter int N_PIX     = 4,
   parameter int SUM_W     = 18,
   parameter int CNT_W     = 13
);
   logic                       start;
   logic [1:0]                 eo_class;
   logic                       in_valid;
   logic                       in_ready;
   logic                       in_last;
   logic [N_PIX-1:0]           in_mask;
   logic [N_PIX*BIT_DEPTH-1:0] rec_m;
   logic [N_PIX*BIT_DEPTH-1:0] rec_a;
   logic [N_PIX*BIT_DEPTH-1:0] rec_b;
   logic [N_PIX*BIT_DEPTH-1:0] org_m;
   logic                       out_valid;
   logic                       out_ready;
   logic [1:0]                 out_class;
   logic [4*SUM_W-1:0]         out_sum;
   logic [4*CNT_W-1:0]         out_cnt;
   logic                       busy;

   modport master (
      output start, eo_class, in_valid, in_last, in_mask, rec_m, rec_a, rec_b, org_m, out_ready,
      input  in_ready, out_valid, out_class, out_sum, out_cnt, busy
   );

   modport slave (
      input  start, eo_class, in_valid, in_last, in_mask, rec_m, rec_a, rec_b, org_m, out_ready,
      output in_ready, out_valid, out_class, out_sum, out_cnt, busy
   );
endinterface

// File: rtl/sao_eo_stat_accum_classify.sv
// One combinational lane: neighbour signs, EO category and clipped org-rec diff.
module sao_eo_classify
   import sao_eo_stat_accum_pkg::*;
#(
   parameter int BIT_DEPTH = BIT_DEPTH_DEF,
   parameter int DCB       = DIFF_CLIP_BIT_DEF
) (
   input  logic [BIT_DEPTH-1:0] i_rec_m,
   input  logic [BIT_DEPTH-1:0] i_rec_a,
   input  logic [BIT_DEPTH-1:0] i_rec_b,
   input  logic [BIT_DEPTH-1:0] i_org_m,
   output sao_cat_e             o_cat,
   output logic signed [DCB:0]  o_diff
);
   localparam int HI_I = (1 << DCB) - 1;
   localparam logic signed [BIT_DEPTH:0] C_HI = HI_I[BIT_DEPTH:0];
   localparam logic signed [BIT_DEPTH:0] C_LO = ~C_HI;

   logic signed [BIT_DEPTH:0] w_da;
   logic signed [BIT_DEPTH:0] w_db;
   logic signed [BIT_DEPTH:0] w_diff;
   sgn_t                      w_sa;
   sgn_t                      w_sb;

   function automatic sgn_t f_sign(input logic signed [BIT_DEPTH:0] v);
      if (v == '0)          return 2'sb00;
      else if (v[BIT_DEPTH]) return 2'sb11;
      else                   return 2'sb01;
   endfunction

   // Signs, category and clip evaluated at bit_depth+1 signed.
   always_comb begin
      w_da   = $signed({1'b0, i_rec_m}) - $signed({1'b0, i_rec_a});
      w_db   = $signed({1'b0, i_rec_m}) - $signed({1'b0, i_rec_b});
      w_diff = $signed({1'b0, i_org_m}) - $signed({1'b0, i_rec_m});
      w_sa   = f_sign(w_da);
      w_sb   = f_sign(w_db);
      o_cat  = sao_eo_cat(w_sa, w_sb);
      if (w_diff > C_HI)      o_diff = C_HI[DCB:0];
      else if (w_diff < C_LO) o_diff = C_LO[DCB:0];
      else                    o_diff = w_diff[DCB:0];
   end
endmodule

// File: rtl/sao_eo_stat_accum.sv
// SAO edge-offset statistics collector: per-category saturating diff sums and
// pixel counts over one CTB, two-stage pipeline behind a small block FSM.
module sao_eo_stat_accum
   import sao_eo_stat_accum_pkg::*;
#(
   parameter int BIT_DEPTH     = BIT_DEPTH_DEF,
   parameter int N_PIX         = 4,
   parameter int DIFF_CLIP_BIT = DIFF_CLIP_BIT_DEF,
   parameter int SUM_W         = 18,
   parameter int CNT_W         = 13
) (
   input logic                clk,
   input logic                rst_n,
   sao_eo_stat_accum_if.slave bus
);
   localparam int DCB   = DIFF_CLIP_BIT;
   localparam int S2_W  = DCB + 2 + $clog2(N_PIX);
   localparam int S2C_W = $clog2(N_PIX + 1);
   localparam int SX_W  = SUM_W + 1;
   localparam int CX_W  = CNT_W + 1;
   localparam logic signed [SUM_W-1:0] C_SUM_MAX = {1'b0, {(SUM_W-1){1'b1}}};
   localparam logic signed [SUM_W-1:0] C_SUM_MIN = {1'b1, {(SUM_W-1){1'b0}}};

   sao_state_e r_state;
   logic [1:0] r_drain;
   logic [1:0] r_class;
   logic       r_in_ready;
   logic       r_out_valid;
   logic       r_busy;

   sao_cat_e              w_cat  [N_PIX];
   logic signed [DCB:0]   w_diff [N_PIX];
   sao_cat_e              r_s1_cat  [N_PIX];
   logic signed [DCB:0]   r_s1_diff [N_PIX];
   logic [N_PIX-1:0]      r_s1_mask;
   logic signed [S2_W-1:0] w_s2_sum [4];
   logic [S2C_W-1:0]       w_s2_cnt [4];
   logic signed [S2_W-1:0] r_s2_sum [4];
   logic [S2C_W-1:0]       r_s2_cnt [4];
   logic signed [SUM_W-1:0] r_acc_sum [4];
   logic [CNT_W-1:0]        r_acc_cnt [4];
   logic signed [SX_W-1:0]  w_sum_ext [4];
   logic [CX_W-1:0]         w_cnt_ext [4];

   logic w_accept;
   logic w_start;
   assign w_accept = bus.in_valid & r_in_ready;
   assign w_start  = bus.start & (r_state == ST_IDLE);

   for (genvar g = 0; g < N_PIX; g++) begin : g_lane
      sao_eo_classify #(.BIT_DEPTH(BIT_DEPTH), .DCB(DCB)) u_cls (
         .i_rec_m (bus.rec_m[g*BIT_DEPTH +: BIT_DEPTH]),
         .i_rec_a (bus.rec_a[g*BIT_DEPTH +: BIT_DEPTH]),
         .i_rec_b (bus.rec_b[g*BIT_DEPTH +: BIT_DEPTH]),
         .i_org_m (bus.org_m[g*BIT_DEPTH +: BIT_DEPTH]),
         .o_cat   (w_cat[g]),
         .o_diff  (w_diff[g])
      );
   end

   // Block FSM; DRAIN waits out the two pipeline stages plus the final accumulate.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state     <= ST_IDLE;
         r_drain     <= 2'd0;
         r_class     <= 2'd0;
         r_in_ready  <= 1'b0;
         r_out_valid <= 1'b0;
         r_busy      <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: if (bus.start) begin
               r_state    <= ST_RUN;
               r_class    <= bus.eo_class;
               r_in_ready <= 1'b1;
               r_busy     <= 1'b1;
            end
            ST_RUN: if (w_accept && bus.in_last) begin
               r_state    <= ST_DRAIN;
               r_drain    <= 2'd0;
               r_in_ready <= 1'b0;
            end
            ST_DRAIN: if (r_drain == 2'd2) begin
               r_state     <= ST_OUT;
               r_out_valid <= 1'b1;
            end else begin
               r_drain <= r_drain + 2'd1;
            end
            ST_OUT: if (bus.out_ready) begin
               r_state     <= ST_IDLE;
               r_out_valid <= 1'b0;
               r_busy      <= 1'b0;
            end
            default: begin
               r_state     <= ST_IDLE;
               r_in_ready  <= 1'b0;
               r_out_valid <= 1'b0;
               r_busy      <= 1'b0;
            end
         endcase
      end
   end

   // S1: lane results; a zero mask doubles as the stage-valid.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_s1_mask <= '0;
         for (int l = 0; l < N_PIX; l++) begin
            r_s1_cat[l]  <= CAT_NONE;
            r_s1_diff[l] <= '0;
         end
      end else begin
         r_s1_mask <= w_accept ? bus.in_mask : '0;
         for (int l = 0; l < N_PIX; l++) begin
            r_s1_cat[l]  <= w_cat[l];
            r_s1_diff[l] <= w_diff[l];
         end
      end
   end

   // Per-category adder trees over the masked lanes.
   always_comb begin
      for (int k = 0; k < 4; k++) begin
         w_s2_sum[k] = '0;
         w_s2_cnt[k] = '0;
         for (int l = 0; l < N_PIX; l++) begin
            w_s2_sum[k] = w_s2_sum[k] + ((r_s1_mask[l] && r_s1_cat[l] == sao_cat_e'(3'(k + 1)))
                                         ? S2_W'(r_s1_diff[l]) : '0);
            w_s2_cnt[k] = w_s2_cnt[k] + S2C_W'(r_s1_mask[l] && r_s1_cat[l] == sao_cat_e'(3'(k + 1)));
         end
         w_sum_ext[k] = SX_W'(r_acc_sum[k]) + SX_W'(r_s2_sum[k]);
         w_cnt_ext[k] = {1'b0, r_acc_cnt[k]} + CX_W'(r_s2_cnt[k]);
      end
   end

   // S2 partial sums and the saturating block accumulators.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int k = 0; k < 4; k++) begin
            r_s2_sum[k]  <= '0;
            r_s2_cnt[k]  <= '0;
            r_acc_sum[k] <= '0;
            r_acc_cnt[k] <= '0;
         end
      end else begin
         for (int k = 0; k < 4; k++) begin
            r_s2_sum[k] <= w_s2_sum[k];
            r_s2_cnt[k] <= w_s2_cnt[k];
            if (w_start) begin
               r_acc_sum[k] <= '0;
               r_acc_cnt[k] <= '0;
            end else begin
               if (w_sum_ext[k][SUM_W] != w_sum_ext[k][SUM_W-1])
                  r_acc_sum[k] <= w_sum_ext[k][SUM_W] ? C_SUM_MIN : C_SUM_MAX;
               else
                  r_acc_sum[k] <= w_sum_ext[k][SUM_W-1:0];
               r_acc_cnt[k] <= w_cnt_ext[k][CNT_W] ? '1 : w_cnt_ext[k][CNT_W-1:0];
            end
         end
      end
   end

   assign bus.in_ready  = r_in_ready;
   assign bus.out_valid = r_out_valid;
   assign bus.out_class = r_class;
   assign bus.busy      = r_busy;

   for (genvar k = 0; k < 4; k++) begin : g_out
      assign bus.out_sum[k*SUM_W +: SUM_W] = r_acc_sum[k];
      assign bus.out_cnt[k*CNT_W +: CNT_W] = r_acc_cnt[k];
   end
endmodule
